// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU front-end: decodes instructions, drives the ALU and issues writebacks.
// One instruction in flight at a time: IDLE accepts, EXEC drives the ALU, WB holds the result.
module alu_issue_ctrl #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        instr,
    input  logic [XLEN-1:0]    rs_data,
    input  logic [XLEN-1:0]    rt_data,
    output logic [3:0]         alu_op,
    output logic [XLEN-1:0]    alu_in_0,
    output logic [XLEN-1:0]    alu_in_1,
    input  logic [XLEN-1:0]    alu_out,
    input  logic               alu_of,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic               wb_en,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [XLEN-1:0]    wb_data,
    output logic               illegal,
    output logic               ovf_trap,
    output logic               ovf_status,
    input  logic               ovf_clr
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADDS = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_SUBS = 4'd6;
    localparam logic [3:0] OP_SHRL = 4'd8;
    localparam logic [3:0] OP_SHLL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [5:0]      opcode;
    logic [3:0]      funct;
    logic [15:0]     imm;
    logic [XLEN-1:0] imm_sext, imm_zext, imm_shamt;

    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_in_0, dec_in_1;
    logic            dec_ill;

    logic            accept, exec_done, wb_done, captured_of;

    assign opcode    = instr[31:26];
    assign funct     = instr[3:0];
    assign imm       = instr[15:0];
    assign imm_sext  = {{(XLEN-16){imm[15]}}, imm};
    assign imm_zext  = {{(XLEN-16){1'b0}}, imm};
    assign imm_shamt = {{(XLEN-5){1'b0}}, imm[4:0]};

    always_comb begin
        dec_op   = OP_NOP;
        dec_in_0 = '0;
        dec_in_1 = '0;
        dec_ill  = 1'b0;
        case (opcode)
            6'h00: begin
                if (funct >= 4'd1 && funct <= 4'd9) begin
                    dec_op   = funct;
                    dec_in_0 = rs_data;
                    dec_in_1 = rt_data;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            6'h08: begin dec_op = OP_ADDS; dec_in_0 = rs_data; dec_in_1 = imm_sext;  end
            6'h09: begin dec_op = OP_ADDU; dec_in_0 = rs_data; dec_in_1 = imm_sext;  end
            6'h0C: begin dec_op = OP_AND;  dec_in_0 = rs_data; dec_in_1 = imm_zext;  end
            6'h0D: begin dec_op = OP_OR;   dec_in_0 = rs_data; dec_in_1 = imm_zext;  end
            6'h0E: begin dec_op = OP_XOR;  dec_in_0 = rs_data; dec_in_1 = imm_zext;  end
            6'h10: begin dec_op = OP_SHLL; dec_in_0 = rs_data; dec_in_1 = imm_shamt; end
            6'h11: begin dec_op = OP_SHRL; dec_in_0 = rs_data; dec_in_1 = imm_shamt; end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        wb_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept      = (state_q == S_IDLE) && in_valid;
    assign exec_done   = (state_q == S_EXEC);
    assign wb_done     = (state_q == S_WB) && wb_ready;
    // Only the signed ops can trap; the ALU may flag overflow for others too.
    assign captured_of = alu_of && (alu_op == OP_ADDS || alu_op == OP_SUBS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            alu_op     <= OP_NOP;
            alu_in_0   <= '0;
            alu_in_1   <= '0;
            wb_en      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            illegal    <= 1'b0;
            ovf_trap   <= 1'b0;
            ovf_status <= 1'b0;
        end else begin
            state_q  <= state_d;
            ovf_trap <= 1'b0;
            if (accept) begin
                alu_op   <= dec_op;
                alu_in_0 <= dec_in_0;
                alu_in_1 <= dec_in_1;
                wb_addr  <= instr[21 +: RADDR_W];
                illegal  <= dec_ill;
            end
            if (exec_done) begin
                wb_data  <= alu_out;
                wb_en    <= !illegal && (wb_addr != '0) && !captured_of;
                ovf_trap <= captured_of;
            end
            if (wb_done) wb_en <= 1'b0;
            // A coincident clear loses to a new overflow.
            if (exec_done && captured_of) ovf_status <= 1'b1;
            else if (ovf_clr)             ovf_status <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] instr, rs_data, rt_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_in_0, alu_in_1, alu_out;
    logic        alu_of;
    logic        wb_valid, wb_ready, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal, ovf_trap, ovf_status, ovf_clr;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
        .alu_out(alu_out), .alu_of(alu_of),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal),
        .ovf_trap(ovf_trap), .ovf_status(ovf_status), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference ALU driven by the DUT's registered outputs.
    logic [31:0] a_sum, a_dif;
    always_comb begin
        a_sum   = alu_in_0 + alu_in_1;
        a_dif   = alu_in_0 - alu_in_1;
        alu_out = '0;
        alu_of  = 1'b0;
        case (alu_op)
            4'd1: alu_out = alu_in_0 & alu_in_1;
            4'd2: alu_out = alu_in_0 | alu_in_1;
            4'd3: alu_out = alu_in_0 ^ alu_in_1;
            4'd4, 4'd5: begin
                alu_out = a_sum;
                alu_of  = (alu_in_0[31] == alu_in_1[31]) && (a_sum[31] != alu_in_0[31]);
            end
            4'd6, 4'd7: begin
                alu_out = a_dif;
                alu_of  = (alu_in_0[31] != alu_in_1[31]) && (a_dif[31] != alu_in_0[31]);
            end
            4'd8: alu_out = alu_in_0 >> alu_in_1[4:0];
            4'd9: alu_out = alu_in_0 << alu_in_1[4:0];
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [3:0] fn);
        return {6'h00, rd, 5'd1, 5'd2, 7'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rd, input logic [15:0] im);
        return {op, rd, 5'd1, im};
    endfunction

    // Leaves the bench one sample point after the accepting edge (EXEC cycle).
    task automatic issue(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        instr    = ins;
        rs_data  = rs;
        rt_data  = rt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; rs_data = '0; rt_data = '0;
        wb_ready = 1'b1; ovf_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_ovf_status", {31'd0, ovf_status}, 32'd0);

        // R-type ADDU rd=3
        issue(rtype(5'd3, 4'd5), 32'h5, 32'h7);
        chk("addu_exec_op", {28'd0, alu_op}, 32'd5);
        chk("addu_exec_in0", alu_in_0, 32'h5);
        chk("addu_exec_in1", alu_in_1, 32'h7);
        chk("addu_exec_in_ready", {31'd0, in_ready}, 32'd0);
        chk("addu_exec_wb_valid", {31'd0, wb_valid}, 32'd0);
        step();
        chk("addu_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("addu_wb_addr", {27'd0, wb_addr}, 32'd3);
        chk("addu_wb_data", wb_data, 32'h0000_000C);
        chk("addu_wb_en", {31'd0, wb_en}, 32'd1);
        chk("addu_wb_illegal", {31'd0, illegal}, 32'd0);
        step();
        chk("addu_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("addu_idle_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("addu_hold_op", {28'd0, alu_op}, 32'd5);

        // ADDI sign-extended immediate
        issue(itype(6'h08, 5'd2, 16'hFFFF), 32'h10, 32'h0);
        chk("addi_op", {28'd0, alu_op}, 32'd4);
        chk("addi_in1", alu_in_1, 32'hFFFF_FFFF);
        step();
        chk("addi_wb_data", wb_data, 32'h0000_000F);
        chk("addi_wb_en", {31'd0, wb_en}, 32'd1);
        chk("addi_no_trap", {31'd0, ovf_trap}, 32'd0);
        step();

        // ANDI zero-extended immediate
        issue(itype(6'h0C, 5'd6, 16'h8001), 32'hFFFF_FFFF, 32'h0);
        chk("andi_op", {28'd0, alu_op}, 32'd1);
        chk("andi_in1", alu_in_1, 32'h0000_8001);
        step();
        chk("andi_wb_data", wb_data, 32'h0000_8001);
        step();

        // SLLI uses only imm[4:0]
        issue(itype(6'h10, 5'd8, 16'h0024), 32'h1, 32'h0);
        chk("slli_op", {28'd0, alu_op}, 32'd9);
        chk("slli_in1", alu_in_1, 32'h4);
        step();
        chk("slli_wb_data", wb_data, 32'h10);
        step();

        // ADDS overflow with 5-cycle backpressure
        wb_ready = 1'b0;
        issue(rtype(5'd4, 4'd4), 32'h7FFF_FFFF, 32'h1);
        step();
        chk("ovf_wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("ovf_wb_en", {31'd0, wb_en}, 32'd0);
        chk("ovf_trap_first", {31'd0, ovf_trap}, 32'd1);
        chk("ovf_status_set", {31'd0, ovf_status}, 32'd1);
        chk("ovf_wb_data", wb_data, 32'h8000_0000);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("stall_wb_data", wb_data, 32'h8000_0000);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_trap", {31'd0, ovf_trap}, 32'd0);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr_clears", {31'd0, ovf_status}, 32'd0);
        wb_ready = 1'b1;
        step();
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_wb_valid", {31'd0, wb_valid}, 32'd0);

        // SUBS overflow with coincident clear: set wins
        issue(rtype(5'd4, 4'd6), 32'h8000_0000, 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("subs_trap", {31'd0, ovf_trap}, 32'd1);
        chk("set_wins_status", {31'd0, ovf_status}, 32'd1);
        step();

        // Illegal opcode
        issue(itype(6'h3F, 5'd5, 16'h1234), 32'hAAAA_AAAA, 32'h5);
        chk("ill_op_alu_op", {28'd0, alu_op}, 32'd0);
        chk("ill_op_in0", alu_in_0, 32'd0);
        step();
        chk("ill_op_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_op_wb_en", {31'd0, wb_en}, 32'd0);
        chk("ill_op_wb_valid", {31'd0, wb_valid}, 32'd1);
        step();

        // Illegal funct 0xA
        issue(rtype(5'd5, 4'hA), 32'h1, 32'h2);
        chk("ill_fn_alu_op", {28'd0, alu_op}, 32'd0);
        step();
        chk("ill_fn_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_fn_wb_en", {31'd0, wb_en}, 32'd0);
        step();

        // Legal ADDU to r0 retires without writing
        issue(rtype(5'd0, 4'd5), 32'h3, 32'h4);
        step();
        chk("r0_wb_en", {31'd0, wb_en}, 32'd0);
        chk("r0_illegal", {31'd0, illegal}, 32'd0);
        chk("r0_wb_data", wb_data, 32'h7);
        step();

        // Reset mid-EXEC
        issue(rtype(5'd9, 4'd2), 32'hF0, 32'h0F);
        #2 rst = 1'b1;
        #1;
        chk("rexec_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rexec_alu_op", {28'd0, alu_op}, 32'd0);
        #1 rst = 1'b0;
        step();
        chk("rexec_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-WB after an overflow
        wb_ready = 1'b0;
        issue(rtype(5'd4, 4'd4), 32'h7FFF_FFFF, 32'h1);
        step();
        chk("rwb_pre_valid", {31'd0, wb_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rwb_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rwb_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rwb_wb_data", wb_data, 32'd0);
        chk("rwb_ovf_status", {31'd0, ovf_status}, 32'd0);
        #1 rst = 1'b0;
        wb_ready = 1'b1;
        step();
        chk("rwb_in_ready", {31'd0, in_ready}, 32'd1);

        // Normal instruction after reset
        issue(rtype(5'd7, 4'd3), 32'h0000_F0F0, 32'h0000_FF00);
        chk("post_rst_op", {28'd0, alu_op}, 32'd3);
        step();
        chk("post_rst_wb_data", wb_data, 32'h0000_0FF0);
        chk("post_rst_wb_addr", {27'd0, wb_addr}, 32'd7);
        chk("post_rst_wb_en", {31'd0, wb_en}, 32'd1);
        step();
        chk("post_rst_idle", {31'd0, in_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
